date_counter: RTL and testbench



---
 rtl/date_counter_pkg.sv | 27 ++
 rtl/date_counter_if.sv | 37 +++
 rtl/date_counter_month_len.sv | 20 ++
 rtl/date_counter.sv | 180 ++++++++++++++++++
 tb/tb_date_counter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/date_counter_pkg.sv
// Shared calendar constants and the Gregorian leap-year helper for the millennium clock.
package calendar_pkg;

    localparam logic [2:0] SEL_DAY_CODE   = 3'b011;
    localparam logic [2:0] SEL_MONTH_CODE = 3'b100;
    localparam logic [2:0] SEL_YEAR_CODE  = 3'b101;
    localparam logic [2:0] SEL_WDAY_CODE  = 3'b110;

    localparam logic [3:0] MONTH_JAN = 4'd1;
    localparam logic [3:0] MONTH_FEB = 4'd2;
    localparam logic [3:0] MONTH_DEC = 4'd12;

    localparam logic [4:0] DAY_FIRST = 5'd1;
    localparam logic [4:0] DAYS_28   = 5'd28;
    localparam logic [4:0] DAYS_29   = 5'd29;
    localparam logic [4:0] DAYS_30   = 5'd30;
    localparam logic [4:0] DAYS_31   = 5'd31;

    localparam logic [2:0] WDAY_FIRST = 3'd0;
    localparam logic [2:0] WDAY_LAST  = 3'd6;

    function automatic logic is_leap(input logic [15:0] year);
        return ((year % 16'd4 == 16'd0) && (year % 16'd100 != 16'd0)) ||
               (year % 16'd400 == 16'd0);
    endfunction

endpackage

// File: rtl/date_counter_if.sv
// Control and date bus of date_counter; wday_bin exists only when DATE_WEEKDAY_EN is defined.
interface date_counter_if #(
    parameter int YEAR_W = 12
);
    logic              en_1;
    logic              carry_in;
    logic              up;
    logic              down;
    logic [2:0]        select_item;
    logic [4:0]        day_bin;
    logic [3:0]        month_bin;
    logic [YEAR_W-1:0] year_bin;
    logic              leap_year;
    logic [4:0]        max_day;
    logic              year_wrap;
`ifdef DATE_WEEKDAY_EN
    logic [2:0]        wday_bin;

    modport master (
        output en_1, carry_in, up, down, select_item,
        input  day_bin, month_bin, year_bin, leap_year, max_day, year_wrap, wday_bin
    );
    modport slave (
        input  en_1, carry_in, up, down, select_item,
        output day_bin, month_bin, year_bin, leap_year, max_day, year_wrap, wday_bin
    );
`else
    modport master (
        output en_1, carry_in, up, down, select_item,
        input  day_bin, month_bin, year_bin, leap_year, max_day, year_wrap
    );
    modport slave (
        input  en_1, carry_in, up, down, select_item,
        output day_bin, month_bin, year_bin, leap_year, max_day, year_wrap
    );
`endif
endinterface

// File: rtl/date_counter_month_len.sv
// cal_month_len: number of days in a month, given the month and the leap flag of its year.
module cal_month_len
    import calendar_pkg::*;
(
    input  logic [3:0] month,
    input  logic       leap_year,
    output logic [4:0] max_day
);

    // Month length lookup
    always_comb begin
        max_day = DAYS_31;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: max_day = DAYS_30;
            MONTH_FEB:               max_day = leap_year ? DAYS_29 : DAYS_28;
            default:                 max_day = DAYS_31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Day/month/year counter with carry advance, manual field adjust and day clamping.
// Optional weekday counter is built when DATE_WEEKDAY_EN is defined.
module date_counter
    import calendar_pkg::*;
#(
    parameter int         YEAR_W    = 12,
    parameter int         YEAR_MIN  = 2000,
    parameter int         YEAR_MAX  = 2999,
    parameter logic [2:0] SEL_DAY   = SEL_DAY_CODE,
    parameter logic [2:0] SEL_MONTH = SEL_MONTH_CODE,
    parameter logic [2:0] SEL_YEAR  = SEL_YEAR_CODE
`ifdef DATE_WEEKDAY_EN
    ,
    parameter logic [2:0] WDAY_RESET = 3'd6,
    parameter logic [2:0] SEL_WDAY   = SEL_WDAY_CODE
`endif
) (
    input  logic          clk_1Hz,
    input  logic          rst,
    date_counter_if.slave bus
);

    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_ONE = YEAR_W'(1'b1);

    logic [4:0]        day_q, day_d, day_step_s;
    logic [3:0]        month_q, month_d;
    logic [YEAR_W-1:0] year_q, year_d;
    logic              wrap_q, wrap_d;
    logic              up_q, down_q;
    logic              up_p_s, down_p_s, step_up_s, step_dn_s;
    logic              edit_sel_s, adv_s;
    logic              leap_s, new_leap_s;
    logic [4:0]        cur_max_s, new_max_s;

    // Button edge detection, field selection and carry qualification
    always_comb begin
        up_p_s     = bus.up & ~up_q;
        down_p_s   = bus.down & ~down_q;
        step_up_s  = up_p_s & ~down_p_s;
        step_dn_s  = down_p_s & ~up_p_s;
        edit_sel_s = (bus.select_item == SEL_DAY) || (bus.select_item == SEL_MONTH) ||
                     (bus.select_item == SEL_YEAR)
`ifdef DATE_WEEKDAY_EN
                     || (bus.select_item == SEL_WDAY)
`endif
                     ;
        adv_s      = bus.en_1 & bus.carry_in & ~edit_sel_s;
        leap_s     = is_leap(16'(year_q));
        new_leap_s = is_leap(16'(year_d));
    end

    cal_month_len u_cur_len (.month(month_q), .leap_year(leap_s),     .max_day(cur_max_s));
    cal_month_len u_new_len (.month(month_d), .leap_year(new_leap_s), .max_day(new_max_s));

    // Field updates before the day is clamped to the length of the resulting month
    always_comb begin
        day_step_s = day_q;
        month_d    = month_q;
        year_d     = year_q;
        wrap_d     = 1'b0;
        if (adv_s) begin
            if (day_q < cur_max_s) begin
                day_step_s = day_q + 5'd1;
            end else begin
                day_step_s = DAY_FIRST;
                if (month_q == MONTH_DEC) begin
                    month_d = MONTH_JAN;
                    if (year_q == Y_MAX) begin
                        year_d = Y_MIN;
                        wrap_d = 1'b1;
                    end else begin
                        year_d = year_q + Y_ONE;
                    end
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else begin
            case (bus.select_item)
                SEL_DAY: begin
                    if (step_up_s) begin
                        day_step_s = (day_q >= cur_max_s) ? DAY_FIRST : day_q + 5'd1;
                    end else if (step_dn_s) begin
                        day_step_s = (day_q <= DAY_FIRST) ? cur_max_s : day_q - 5'd1;
                    end else begin
                        day_step_s = day_q;
                    end
                end
                SEL_MONTH: begin
                    if (step_up_s) begin
                        month_d = (month_q >= MONTH_DEC) ? MONTH_JAN : month_q + 4'd1;
                    end else if (step_dn_s) begin
                        month_d = (month_q <= MONTH_JAN) ? MONTH_DEC : month_q - 4'd1;
                    end else begin
                        month_d = month_q;
                    end
                end
                SEL_YEAR: begin
                    if (step_up_s) begin
                        year_d = (year_q >= Y_MAX) ? Y_MIN : year_q + Y_ONE;
                    end else if (step_dn_s) begin
                        year_d = (year_q <= Y_MIN) ? Y_MAX : year_q - Y_ONE;
                    end else begin
                        year_d = year_q;
                    end
                end
                default: begin
                    day_step_s = day_q;
                end
            endcase
        end
    end

    // Shorter target month pulls the day back to its last valid value
    always_comb begin
        if (day_step_s > new_max_s) begin
            day_d = new_max_s;
        end else begin
            day_d = day_step_s;
        end
    end

    // Date state registers
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            day_q   <= DAY_FIRST;
            month_q <= MONTH_JAN;
            year_q  <= Y_MIN;
            wrap_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wrap_q  <= wrap_d;
            up_q    <= bus.up;
            down_q  <= bus.down;
        end
    end

    assign bus.day_bin   = day_q;
    assign bus.month_bin = month_q;
    assign bus.year_bin  = year_q;
    assign bus.leap_year = leap_s;
    assign bus.max_day   = cur_max_s;
    assign bus.year_wrap = wrap_q;

`ifdef DATE_WEEKDAY_EN
    logic [2:0] wday_q, wday_d;

    // Weekday follows every carry advance and its own manual edits only
    always_comb begin
        wday_d = wday_q;
        if (adv_s) begin
            wday_d = (wday_q >= WDAY_LAST) ? WDAY_FIRST : wday_q + 3'd1;
        end else if ((bus.select_item == SEL_WDAY) && step_up_s) begin
            wday_d = (wday_q >= WDAY_LAST) ? WDAY_FIRST : wday_q + 3'd1;
        end else if ((bus.select_item == SEL_WDAY) && step_dn_s) begin
            wday_d = (wday_q == WDAY_FIRST) ? WDAY_LAST : wday_q - 3'd1;
        end else begin
            wday_d = wday_q;
        end
    end

    // Weekday register
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            wday_q <= WDAY_RESET;
        end else begin
            wday_q <= wday_d;
        end
    end

    assign bus.wday_bin = wday_q;
`endif

endmodule

// File: tb/tb_date_counter.sv
// Scoreboard bench for date_counter: directed calendar cases plus random stimulus vs. a date model.
module tb_date_counter;
    localparam int YMIN = 2000;
    localparam int YMAX = 2999;

    typedef struct {
        int d; int m; int y; int w; int wrap; int leap; int maxd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // model state
    int md, mm, my, mw, mwrap;
    bit prev_up, prev_dn;

    date_counter_if #(.YEAR_W(12)) bus ();
    date_counter dut (.clk_1Hz(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic int leap_of(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0) ? 1 : 0;
    endfunction

    function automatic int dim(input int m, input int y);
        if (m == 2) return 28 + leap_of(y);
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // one clock of stimulus; the model's next state goes to the scoreboard
    task automatic cycle(input bit r, input bit en, input bit c, input bit u, input bit dn, input logic [2:0] sel);
        bit upp, dnp, edit;
        int dir, span;
        exp_t e;
        @(negedge clk);
        rst = r; bus.en_1 = en; bus.carry_in = c; bus.up = u; bus.down = dn; bus.select_item = sel;
        @(posedge clk);
        #1;
        upp = u && !prev_up;
        dnp = dn && !prev_dn;
        prev_up = u; prev_dn = dn;
        edit = (sel == 3'd3) || (sel == 3'd4) || (sel == 3'd5);
`ifdef DATE_WEEKDAY_EN
        edit = edit || (sel == 3'd6);
`endif
        mwrap = 0;
        if (r) begin
            md = 1; mm = 1; my = YMIN; mw = 6; prev_up = 0; prev_dn = 0;
        end else if (en && c && !edit) begin
            mw = (mw + 1) % 7;
            md++;
            if (md > dim(mm, my)) begin
                md = 1; mm++;
                if (mm > 12) begin
                    mm = 1; my++;
                    if (my > YMAX) begin my = YMIN; mwrap = 1; end
                end
            end
        end else if (upp != dnp) begin
            dir  = upp ? 1 : -1;
            span = YMAX - YMIN + 1;
            if (sel == 3'd3) md = ((md - 1 + dir + dim(mm, my)) % dim(mm, my)) + 1;
            if (sel == 3'd4) mm = ((mm - 1 + dir + 12) % 12) + 1;
            if (sel == 3'd5) my = YMIN + ((my - YMIN + dir + span) % span);
`ifdef DATE_WEEKDAY_EN
            if (sel == 3'd6) mw = (mw + dir + 7) % 7;
`endif
            if (md > dim(mm, my)) md = dim(mm, my);
        end
        e.d = md; e.m = mm; e.y = my; e.w = mw; e.wrap = mwrap;
        e.leap = leap_of(my); e.maxd = dim(mm, my);
        exp_q.push_back(e);
    endtask

    // monitor: outputs are registered, so every cycle presents one result
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("day",  int'(bus.day_bin),   e.d);
            chk("month", int'(bus.month_bin), e.m);
            chk("year", int'(bus.year_bin),  e.y);
            chk("year_wrap", int'(bus.year_wrap), e.wrap);
            chk("leap_year", int'(bus.leap_year), e.leap);
            chk("max_day", int'(bus.max_day), e.maxd);
`ifdef DATE_WEEKDAY_EN
            chk("wday", int'(bus.wday_bin), e.w);
`endif
        end
    end

    task automatic press(input logic [2:0] sel, input bit is_up, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, is_up, !is_up, sel);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, sel);
        end
    endtask

    task automatic carry(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic expect_date(input string name, input int d, input int m, input int y);
        chk({name, ".day"}, int'(bus.day_bin), d);
        chk({name, ".month"}, int'(bus.month_bin), m);
        chk({name, ".year"}, int'(bus.year_bin), y);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    initial begin
        rst = 1'b1; bus.en_1 = 1'b0; bus.carry_in = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
        bus.select_item = 3'd0;
        md = 0; mm = 0; my = 0; mw = 0; mwrap = 0; prev_up = 0; prev_dn = 0;
        do_reset(); do_reset();
        expect_date("reset", 1, 1, 2000);
        chk("reset.wrap", int'(bus.year_wrap), 0);

        carry(2);
        expect_date("two_carries", 3, 1, 2000);
        do_reset();
        expect_date("mid_reset", 1, 1, 2000);

        // 2000 is leap: 02-28 -> 02-29 -> 03-01
        press(3'b100, 1'b1, 1);
        press(3'b011, 1'b0, 2);
        expect_date("preset_2000", 28, 2, 2000);
        carry(1);
        expect_date("leap_2000", 29, 2, 2000);
        carry(1);
        expect_date("leap_2000_next", 1, 3, 2000);

        // 2100 is not leap: 02-28 -> 03-01
        press(3'b100, 1'b0, 1);
        press(3'b011, 1'b0, 2);
        press(3'b101, 1'b1, 100);
        expect_date("preset_2100", 28, 2, 2100);
        chk("leap_2100", int'(bus.leap_year), 0);
        carry(1);
        expect_date("noleap_2100", 1, 3, 2100);

        // 2999-12-31 rolls over with a single-cycle wrap pulse
        do_reset();
        press(3'b101, 1'b0, 1);
        press(3'b100, 1'b0, 1);
        press(3'b011, 1'b0, 1);
        expect_date("preset_2999", 31, 12, 2999);
        carry(1);
        expect_date("rollover", 1, 1, 2000);
        chk("wrap_pulse", int'(bus.year_wrap), 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("wrap_single", int'(bus.year_wrap), 0);

        // 2001-03-31, month up held 5 cycles -> 04-30 once
        press(3'b101, 1'b1, 1);
        press(3'b100, 1'b1, 2);
        press(3'b011, 1'b0, 1);
        expect_date("preset_0331", 31, 3, 2001);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
        expect_date("month_up_clamp", 30, 4, 2001);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);

        // 2001-01-31 month down -> 12-31
        do_reset();
        press(3'b101, 1'b1, 1);
        press(3'b011, 1'b0, 1);
        press(3'b100, 1'b0, 1);
        expect_date("month_down_wrap", 31, 12, 2001);

        // carry dropped while editing; simultaneous edges ignored
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b011);
        expect_date("carry_dropped", 31, 12, 2001);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b011);
        expect_date("both_edges", 31, 12, 2001);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011);

`ifdef DATE_WEEKDAY_EN
        do_reset();
        carry(7);
        chk("wday_7carries", int'(bus.wday_bin), 6);
        press(3'b110, 1'b1, 1);
        chk("wday_up_wrap", int'(bus.wday_bin), 0);
        press(3'b110, 1'b0, 1);
        chk("wday_down_wrap", int'(bus.wday_bin), 6);
`endif

        // random phase
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
